// File: rtl/ls_pkg.sv
// Shared types and helpers for the load/store request issuer.
//   XLEN / OOO_TAG_SIZE / OOO_ROB_SIZE : datapath widths of the request payload
//   LS_BYTE / LS_HALF / LS_WORD        : size encodings (3 is illegal)
//   ls_req_t                           : one queued load/store uop
//   is_misaligned()                    : trap check applied when an entry is dequeued
package ls_pkg;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned OOO_TAG_SIZE = 10;
  localparam int unsigned OOO_ROB_SIZE = 10;

  localparam logic [1:0] LS_BYTE = 2'd0;
  localparam logic [1:0] LS_HALF = 2'd1;
  localparam logic [1:0] LS_WORD = 2'd2;

  typedef struct packed {
    logic [XLEN-1:0]         addr;
    logic [XLEN-1:0]         data;
    logic [1:0]              size;
    logic                    is_st;
    logic                    sext;
    logic [OOO_TAG_SIZE-1:0] tag;
    logic [OOO_ROB_SIZE-1:0] rob;
  } ls_req_t;

  // Only the two low address bits matter for natural alignment.
  function automatic logic is_misaligned(input logic [1:0] addr_lo,
                                         input logic [1:0] size);
    logic mis;
    case (size)
      LS_BYTE: mis = 1'b0;
      LS_HALF: mis = addr_lo[0];
      LS_WORD: mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/ls_req_fifo.sv
// In-order request FIFO of ls_req_t with flush.
//   clk, rst       : clock, asynchronous active-low reset
//   i_flush        : drop all entries; a push/pop in the same cycle is ignored
//   i_push/i_wdata : enqueue (ignored when full)
//   i_pop          : dequeue head (ignored when empty)
//   o_rdata        : current head entry
//   o_full/o_empty : occupancy flags
module ls_req_fifo
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    i_flush,
  input  logic    i_push,
  input  ls_req_t i_wdata,
  input  logic    i_pop,
  output ls_req_t o_rdata,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  ls_req_t     r_mem [DEPTH];
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  logic        w_push;
  logic        w_pop;

  // Extra pointer MSB distinguishes full from empty after wrap-around.
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_rdata = r_mem[r_rd_ptr[AW-1:0]];

  // Pointer update; flush simply realigns the pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers qualify every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/ls_req_issuer.sv
// Data-cache request initiator: queues backend load/store uops, issues them
// one per cycle to the memory system under dc_stall and an in-flight credit
// limit, traps misaligned/illegal-size accesses locally, and forwards cache
// responses to the backend writeback path. rob_resteer drops everything.
//   clk, rst                      : clock, asynchronous active-low reset
//   req_*                         : backend request (valid/ready handshake)
//   ls_unit_alloc, addr_in, ...   : registered request to the memory system
//   dc_stall                      : memory cannot accept this cycle
//   valid_out, data_out, ...      : memory response
//   rob_resteer                   : ROB flush
//   wb_*                          : registered writeback pulse to backend
//   exc_*                         : registered misalignment trap pulse
module ls_req_issuer
  import ls_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned MAX_OUT = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  // backend request
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [XLEN-1:0]         req_addr,
  input  logic [XLEN-1:0]         req_data,
  input  logic [1:0]              req_size,
  input  logic                    req_is_st,
  input  logic                    req_sext,
  input  logic [OOO_TAG_SIZE-1:0] req_tag,
  input  logic [OOO_ROB_SIZE-1:0] req_rob,
  // request to memory system
  output logic                    ls_unit_alloc,
  output logic [XLEN-1:0]         addr_in,
  output logic [XLEN-1:0]         data_in,
  output logic [1:0]              size_in,
  output logic                    is_st_in,
  output logic                    sext,
  output logic [OOO_TAG_SIZE-1:0] ooo_tag_in,
  output logic [OOO_ROB_SIZE-1:0] ooo_rob_in,
  input  logic                    dc_stall,
  // response from memory system
  input  logic                    valid_out,
  input  logic [XLEN-1:0]         data_out,
  input  logic [OOO_TAG_SIZE-1:0] tag_out,
  input  logic [OOO_ROB_SIZE-1:0] rob_line_out,
  input  logic                    is_flush_out,
  // flush
  input  logic                    rob_resteer,
  // writeback to backend
  output logic                    wb_valid,
  output logic [OOO_TAG_SIZE-1:0] wb_tag,
  output logic [OOO_ROB_SIZE-1:0] wb_rob,
  output logic [XLEN-1:0]         wb_data,
  // misalignment trap
  output logic                    exc_valid,
  output logic [OOO_TAG_SIZE-1:0] exc_tag,
  output logic [OOO_ROB_SIZE-1:0] exc_rob
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  typedef enum logic {
    OS_EMPTY = 1'b0,
    OS_HELD  = 1'b1
  } os_state_t;

  os_state_t               r_os_state;
  os_state_t               w_os_next;
  ls_req_t                 r_os_req;
  logic [CW-1:0]           r_count;

  logic                    r_wb_valid;
  logic [OOO_TAG_SIZE-1:0] r_wb_tag;
  logic [OOO_ROB_SIZE-1:0] r_wb_rob;
  logic [XLEN-1:0]         r_wb_data;

  logic                    r_exc_valid;
  logic [OOO_TAG_SIZE-1:0] r_exc_tag;
  logic [OOO_ROB_SIZE-1:0] r_exc_rob;

  ls_req_t                 w_in_req;
  ls_req_t                 w_head;
  logic                    w_fifo_full;
  logic                    w_fifo_empty;
  logic                    w_push;
  logic                    w_accept;
  logic                    w_resp;
  logic                    w_dec;
  logic                    w_credit_ok;
  logic                    w_pop;
  logic                    w_trap;
  logic                    w_load;

  assign w_in_req = '{addr:  req_addr,
                      data:  req_data,
                      size:  req_size,
                      is_st: req_is_st,
                      sext:  req_sext,
                      tag:   req_tag,
                      rob:   req_rob};

  assign req_ready = !w_fifo_full;
  assign w_push    = req_valid && !w_fifo_full && !rob_resteer;

  ls_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (rob_resteer),
    .i_push  (w_push),
    .i_wdata (w_in_req),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Issue control: a response returning this edge frees a credit early.
  assign w_accept    = (r_os_state == OS_HELD) && !dc_stall;
  assign w_resp      = valid_out && !is_flush_out;
  assign w_dec       = w_resp && (r_count != '0);
  assign w_credit_ok = (r_count < CW'(MAX_OUT)) || w_dec;
  assign w_pop       = !w_fifo_empty && !rob_resteer && w_credit_ok &&
                       ((r_os_state == OS_EMPTY) || w_accept);
  assign w_trap      = w_pop && is_misaligned(w_head.addr[1:0], w_head.size);
  assign w_load      = w_pop && !w_trap;

  // Output-stage state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_os_state <= OS_EMPTY;
    else      r_os_state <= w_os_next;
  end

  // Output-stage next state: refill on the same edge it is accepted
  always_comb begin
    w_os_next = r_os_state;
    case (r_os_state)
      OS_EMPTY: if (w_load) w_os_next = OS_HELD;
      OS_HELD:  if (w_accept && !w_load) w_os_next = OS_EMPTY;
      default:  w_os_next = OS_EMPTY;
    endcase
    if (rob_resteer) w_os_next = OS_EMPTY;
  end

  // Output-stage payload; held while stalled since it only loads on w_load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_os_req <= '0;
    else if (w_load) r_os_req <= w_head;
  end

  // In-flight credit count (output stage plus memory)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (rob_resteer) begin
      r_count <= '0;
    end else begin
      case ({w_load, w_dec})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Writeback pulse, one per surviving response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wb_valid <= 1'b0;
      r_wb_tag   <= '0;
      r_wb_rob   <= '0;
      r_wb_data  <= '0;
    end else begin
      r_wb_valid <= w_resp && !rob_resteer;
      if (w_resp) begin
        r_wb_tag  <= tag_out;
        r_wb_rob  <= rob_line_out;
        r_wb_data <= data_out;
      end
    end
  end

  // Trap pulse; w_trap already excludes flush cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_exc_valid <= 1'b0;
      r_exc_tag   <= '0;
      r_exc_rob   <= '0;
    end else begin
      r_exc_valid <= w_trap;
      if (w_trap) begin
        r_exc_tag <= w_head.tag;
        r_exc_rob <= w_head.rob;
      end
    end
  end

  assign ls_unit_alloc = (r_os_state == OS_HELD);
  assign addr_in       = r_os_req.addr;
  assign data_in       = r_os_req.data;
  assign size_in       = r_os_req.size;
  assign is_st_in      = r_os_req.is_st;
  assign sext          = r_os_req.sext;
  assign ooo_tag_in    = r_os_req.tag;
  assign ooo_rob_in    = r_os_req.rob;

  assign wb_valid  = r_wb_valid;
  assign wb_tag    = r_wb_tag;
  assign wb_rob    = r_wb_rob;
  assign wb_data   = r_wb_data;

  assign exc_valid = r_exc_valid;
  assign exc_tag   = r_exc_tag;
  assign exc_rob   = r_exc_rob;

endmodule

// File: tb/tb_ls_req_issuer.sv
// Directed self-checking bench for ls_req_issuer.
module tb_ls_req_issuer;
  import ls_pkg::*;

  logic                    clk;
  logic                    rst;
  logic                    req_valid;
  logic                    req_ready;
  logic [XLEN-1:0]         req_addr;
  logic [XLEN-1:0]         req_data;
  logic [1:0]              req_size;
  logic                    req_is_st;
  logic                    req_sext;
  logic [OOO_TAG_SIZE-1:0] req_tag;
  logic [OOO_ROB_SIZE-1:0] req_rob;
  logic                    ls_unit_alloc;
  logic [XLEN-1:0]         addr_in;
  logic [XLEN-1:0]         data_in;
  logic [1:0]              size_in;
  logic                    is_st_in;
  logic                    sext;
  logic [OOO_TAG_SIZE-1:0] ooo_tag_in;
  logic [OOO_ROB_SIZE-1:0] ooo_rob_in;
  logic                    dc_stall;
  logic                    valid_out;
  logic [XLEN-1:0]         data_out;
  logic [OOO_TAG_SIZE-1:0] tag_out;
  logic [OOO_ROB_SIZE-1:0] rob_line_out;
  logic                    is_flush_out;
  logic                    rob_resteer;
  logic                    wb_valid;
  logic [OOO_TAG_SIZE-1:0] wb_tag;
  logic [OOO_ROB_SIZE-1:0] wb_rob;
  logic [XLEN-1:0]         wb_data;
  logic                    exc_valid;
  logic [OOO_TAG_SIZE-1:0] exc_tag;
  logic [OOO_ROB_SIZE-1:0] exc_rob;

  int n_checks = 0;
  int n_errors = 0;
  int n_acc    = 0;
  int acc0;

  ls_req_issuer #(.DEPTH(8), .MAX_OUT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .req_size      (req_size),
    .req_is_st     (req_is_st),
    .req_sext      (req_sext),
    .req_tag       (req_tag),
    .req_rob       (req_rob),
    .ls_unit_alloc (ls_unit_alloc),
    .addr_in       (addr_in),
    .data_in       (data_in),
    .size_in       (size_in),
    .is_st_in      (is_st_in),
    .sext          (sext),
    .ooo_tag_in    (ooo_tag_in),
    .ooo_rob_in    (ooo_rob_in),
    .dc_stall      (dc_stall),
    .valid_out     (valid_out),
    .data_out      (data_out),
    .tag_out       (tag_out),
    .rob_line_out  (rob_line_out),
    .is_flush_out  (is_flush_out),
    .rob_resteer   (rob_resteer),
    .wb_valid      (wb_valid),
    .wb_tag        (wb_tag),
    .wb_rob        (wb_rob),
    .wb_data       (wb_data),
    .exc_valid     (exc_valid),
    .exc_tag       (exc_tag),
    .exc_rob       (exc_rob)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Count requests handed to memory (alloc high, no stall at the edge).
  always @(posedge clk) begin
    if (rst && ls_unit_alloc && !dc_stall) n_acc++;
  end

  // A non-flush response must never arrive with no credit outstanding.
  always @(posedge clk) begin
    if (rst && valid_out && !is_flush_out && !rob_resteer)
      chk("credit_nonzero_on_resp", 64'(dut.r_count != '0), 64'd1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                           input logic st, input logic [9:0] tg, input logic [9:0] rb);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    req_size  = sz;
    req_is_st = st;
    req_sext  = 1'b0;
    req_tag   = tg;
    req_rob   = rb;
  endtask

  task automatic drive_resp(input logic [9:0] tg, input logic [9:0] rb, input logic [31:0] d);
    valid_out    = 1'b1;
    tag_out      = tg;
    rob_line_out = rb;
    data_out     = d;
  endtask

  task automatic flush();
    rob_resteer = 1'b1;
    tick();
    rob_resteer = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0;
    req_is_st = 1'b0; req_sext = 1'b0; req_tag = '0; req_rob = '0;
    dc_stall = 1'b0; valid_out = 1'b0; data_out = '0; tag_out = '0;
    rob_line_out = '0; is_flush_out = 1'b0; rob_resteer = 1'b0;

    // Reset values
    tick();
    chk("rst_alloc", 64'(ls_unit_alloc), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_exc_valid", 64'(exc_valid), 64'd0);
    chk("rst_addr_in", 64'(addr_in), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("rel_req_ready", 64'(req_ready), 64'd1);

    // 1: basic load, two-edge latency, writeback
    drive_req(32'h100, 32'h0, LS_WORD, 1'b0, 10'd5, 10'd3);
    tick();
    req_valid = 1'b0;
    chk("t1_alloc_after_enq", 64'(ls_unit_alloc), 64'd0);
    tick();
    chk("t1_alloc", 64'(ls_unit_alloc), 64'd1);
    chk("t1_addr_in", 64'(addr_in), 64'h100);
    chk("t1_tag_in", 64'(ooo_tag_in), 64'd5);
    chk("t1_rob_in", 64'(ooo_rob_in), 64'd3);
    chk("t1_size_in", 64'(size_in), 64'd2);
    tick();
    chk("t1_alloc_drop", 64'(ls_unit_alloc), 64'd0);
    drive_resp(10'd5, 10'd3, 32'hDEADBEEF);
    tick();
    valid_out = 1'b0;
    chk("t1_wb_valid", 64'(wb_valid), 64'd1);
    chk("t1_wb_tag", 64'(wb_tag), 64'd5);
    chk("t1_wb_rob", 64'(wb_rob), 64'd3);
    chk("t1_wb_data", 64'(wb_data), 64'hDEADBEEF);
    tick();
    chk("t1_wb_pulse", 64'(wb_valid), 64'd0);

    // 2: store held stable under stall, accepted once
    acc0 = n_acc;
    dc_stall = 1'b1;
    drive_req(32'h200, 32'h12345678, LS_WORD, 1'b1, 10'd9, 10'd4);
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_alloc_held", 64'(ls_unit_alloc), 64'd1);
      chk("t2_addr_held", 64'(addr_in), 64'h200);
      chk("t2_data_held", 64'(data_in), 64'h12345678);
      chk("t2_is_st_held", 64'(is_st_in), 64'd1);
    end
    dc_stall = 1'b0;
    tick();
    chk("t2_alloc_after_accept", 64'(ls_unit_alloc), 64'd0);
    chk("t2_issue_once", 64'(n_acc - acc0), 64'd1);
    drive_resp(10'd9, 10'd4, 32'h0);
    tick();
    valid_out = 1'b0;
    chk("t2_wb_tag", 64'(wb_tag), 64'd9);

    // 3: backpressure and credit limit
    acc0 = n_acc;
    dc_stall = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive_req(32'h300 + 32'(4 * i), 32'(i), LS_WORD, 1'b0, 10'(16 + i), 10'(i));
      tick();
      if (i == 7) chk("t3_ready_before_full", 64'(req_ready), 64'd1);
    end
    req_valid = 1'b0;
    chk("t3_ready_full", 64'(req_ready), 64'd0);
    chk("t3_alloc", 64'(ls_unit_alloc), 64'd1);
    chk("t3_addr_head", 64'(addr_in), 64'h300);
    dc_stall = 1'b0;
    repeat (10) tick();
    chk("t3_issued_max_out", 64'(n_acc - acc0), 64'd4);
    chk("t3_alloc_blocked", 64'(ls_unit_alloc), 64'd0);
    chk("t3_ready_after", 64'(req_ready), 64'd1);
    flush();

    // 4: misaligned word traps, next aligned request issues
    drive_req(32'h102, 32'h0, LS_WORD, 1'b0, 10'd7, 10'd8);
    tick();
    drive_req(32'h104, 32'h0, LS_WORD, 1'b0, 10'd8, 10'd9);
    tick();
    req_valid = 1'b0;
    chk("t4_exc_valid", 64'(exc_valid), 64'd1);
    chk("t4_exc_tag", 64'(exc_tag), 64'd7);
    chk("t4_exc_rob", 64'(exc_rob), 64'd8);
    chk("t4_no_alloc", 64'(ls_unit_alloc), 64'd0);
    tick();
    chk("t4_exc_pulse", 64'(exc_valid), 64'd0);
    chk("t4_next_alloc", 64'(ls_unit_alloc), 64'd1);
    chk("t4_next_addr", 64'(addr_in), 64'h104);
    tick();
    drive_resp(10'd8, 10'd9, 32'hA5A5);
    tick();
    valid_out = 1'b0;
    chk("t4_wb_tag", 64'(wb_tag), 64'd8);

    // 4b: more trap vectors (odd half, illegal size, misaligned word)
    begin
      logic [31:0] va [3];
      logic [1:0]  vs [3];
      va[0] = 32'h101; vs[0] = LS_HALF;
      va[1] = 32'h100; vs[1] = 2'd3;
      va[2] = 32'h10A; vs[2] = LS_WORD;
      for (int i = 0; i < 3; i++) begin
        drive_req(va[i], 32'h0, vs[i], 1'b0, 10'(20 + i), 10'(30 + i));
        tick();
        req_valid = 1'b0;
        tick();
        chk("t4b_exc_valid", 64'(exc_valid), 64'd1);
        chk("t4b_exc_tag", 64'(exc_tag), 64'(20 + i));
        chk("t4b_no_alloc", 64'(ls_unit_alloc), 64'd0);
        tick();
      end
    end
    // byte at odd address is legal
    drive_req(32'h107, 32'h0, LS_BYTE, 1'b0, 10'd33, 10'd34);
    tick();
    req_valid = 1'b0;
    tick();
    chk("t4c_byte_alloc", 64'(ls_unit_alloc), 64'd1);
    chk("t4c_byte_no_exc", 64'(exc_valid), 64'd0);
    tick();
    drive_resp(10'd33, 10'd34, 32'h7F);
    tick();
    valid_out = 1'b0;

    // 5: flush with three queued plus one stalled in the output stage
    dc_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_req(32'h400 + 32'(4 * i), 32'h0, LS_WORD, 1'b0, 10'(40 + i), 10'(i));
      tick();
    end
    chk("t5_alloc_pre", 64'(ls_unit_alloc), 64'd1);
    drive_req(32'h500, 32'h0, LS_WORD, 1'b0, 10'd99, 10'd99);
    drive_resp(10'd40, 10'd0, 32'h1111);
    rob_resteer = 1'b1;
    tick();
    rob_resteer = 1'b0;
    req_valid = 1'b0;
    valid_out = 1'b0;
    chk("t5_alloc_flushed", 64'(ls_unit_alloc), 64'd0);
    chk("t5_ready", 64'(req_ready), 64'd1);
    chk("t5_wb_dropped", 64'(wb_valid), 64'd0);
    repeat (2) tick();
    chk("t5_stays_empty", 64'(ls_unit_alloc), 64'd0);
    drive_resp(10'd41, 10'd1, 32'h2222);
    is_flush_out = 1'b1;
    tick();
    valid_out = 1'b0;
    is_flush_out = 1'b0;
    chk("t5_flush_resp_no_wb", 64'(wb_valid), 64'd0);
    // credit count restarted from zero: four fresh requests may issue
    dc_stall = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 5; i++) begin
      drive_req(32'h600 + 32'(4 * i), 32'h0, LS_WORD, 1'b0, 10'(60 + i), 10'(i));
      tick();
    end
    req_valid = 1'b0;
    repeat (10) tick();
    chk("t5_credits_reset", 64'(n_acc - acc0), 64'd4);
    flush();

    // 6: asynchronous reset mid-stall
    dc_stall = 1'b1;
    drive_req(32'h700, 32'h0, LS_WORD, 1'b0, 10'd50, 10'd5);
    tick();
    req_valid = 1'b0;
    tick();
    drive_resp(10'd50, 10'd5, 32'hCAFE);
    tick();
    valid_out = 1'b0;
    chk("t6_alloc_pre", 64'(ls_unit_alloc), 64'd1);
    chk("t6_wb_pre", 64'(wb_valid), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_alloc_async", 64'(ls_unit_alloc), 64'd0);
    chk("t6_wb_async", 64'(wb_valid), 64'd0);
    chk("t6_exc_async", 64'(exc_valid), 64'd0);
    chk("t6_addr_async", 64'(addr_in), 64'd0);
    tick();
    rst = 1'b1;
    dc_stall = 1'b0;
    tick();
    chk("t6_ready_after", 64'(req_ready), 64'd1);
    chk("t6_alloc_after", 64'(ls_unit_alloc), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
